if_id_stage: RTL

- IF/ID pipeline register and the instruction-side redirect controller for the 5-stage core.
- Captures the fetch stage's `pc_next` and instruction each cycle, and decodes the MIPS-style fields for ID.
- Drives the fetch stage's `pc_branch`/`pc_source` pair back. The fetch PC register cannot be stalled, so this block merges MEM-stage branch redirects with stall-replay redirects so no fetched instruction is lost or duplicated.

---
 rtl/if_id_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register plus instruction-side redirect control.
//
// The fetch PC register cannot be stalled. An ID stall is therefore turned into a
// redirect back to the PC that fetch just produced, and the stage replays it. A MEM
// branch redirect takes priority over any stall and flushes the instruction in ID.
//
// Ports:
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_if_pc_next, i_if_instruction  fetch outputs (fetched PC + 4, instruction word)
//   i_mem_branch_taken/_target   branch resolved taken in MEM and its target
//   i_id_stall                   hazard unit requests that ID hold
//   o_fetch_pc_branch/_source    redirect address and select back to fetch
//   o_id_valid, o_id_pc_next, o_id_instruction  ID registers
//   o_id_opcode/rs/rt/rd/funct, o_id_imm_sext, o_id_branch_target  decoded fields
//
// Optional feature, macro IF_ID_PERF_CNT_EN: adds parameter CNT_WIDTH and the
// saturating outputs o_flush_count (branch cycles) and o_stall_count (stall cycles
// without a branch).
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef IF_ID_PERF_CNT_EN
    , parameter int unsigned CNT_WIDTH = 16
`endif
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_pc_next,
    input  logic [31:0] i_if_instruction,
    input  logic        i_mem_branch_taken,
    input  logic [31:0] i_mem_branch_target,
    input  logic        i_id_stall,
    output logic [31:0] o_fetch_pc_branch,
    output logic        o_fetch_pc_source,
    output logic        o_id_valid,
    output logic [31:0] o_id_pc_next,
    output logic [31:0] o_id_instruction,
    output logic [5:0]  o_id_opcode,
    output logic [4:0]  o_id_rs,
    output logic [4:0]  o_id_rt,
    output logic [4:0]  o_id_rd,
    output logic [5:0]  o_id_funct,
    output logic [31:0] o_id_imm_sext,
    output logic [31:0] o_id_branch_target
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] o_flush_count,
    output logic [CNT_WIDTH-1:0] o_stall_count
`endif
);

    typedef enum logic {S_RUN, S_STALL} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_replay_pc;
    logic        r_id_valid;
    logic [31:0] r_id_pc_next;
    logic [31:0] r_id_instr;

    logic [31:0] w_fetched_pc;
    logic        w_load;
    logic        w_flush;
    logic        w_replay_load;

    // PC of the instruction fetch is presenting this cycle.
    assign w_fetched_pc = i_if_pc_next - 32'd4;

    always_comb begin
        w_next_state      = r_state;
        w_load            = 1'b0;
        w_flush           = 1'b0;
        w_replay_load     = 1'b0;
        o_fetch_pc_source = 1'b0;
        o_fetch_pc_branch = 32'd0;
        if (i_reset) begin
            w_next_state = S_RUN;
        end else if (i_mem_branch_taken) begin
            o_fetch_pc_source = 1'b1;
            o_fetch_pc_branch = i_mem_branch_target;
            w_flush           = 1'b1;
            w_next_state      = S_RUN;
        end else if (i_id_stall) begin
            o_fetch_pc_source = 1'b1;
            w_next_state      = S_STALL;
            if (r_state == S_RUN) begin
                // First stall cycle: latch the PC that must be refetched.
                o_fetch_pc_branch = w_fetched_pc;
                w_replay_load     = 1'b1;
            end else begin
                // Fetch has moved past the replay PC again; keep pointing it back.
                o_fetch_pc_branch = r_replay_pc;
            end
        end else begin
            // In STALL this is the replayed instruction; load is identical.
            w_load       = 1'b1;
            w_next_state = S_RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_RUN;
            r_replay_pc  <= 32'd0;
            r_id_valid   <= 1'b0;
            r_id_pc_next <= 32'd0;
            r_id_instr   <= NOP_INSTR;
        end else begin
            r_state <= w_next_state;
            if (w_replay_load) r_replay_pc <= w_fetched_pc;
            if (w_flush) begin
                r_id_valid   <= 1'b0;
                r_id_pc_next <= 32'd0;
                r_id_instr   <= NOP_INSTR;
            end else if (w_load) begin
                r_id_valid   <= 1'b1;
                r_id_pc_next <= i_if_pc_next;
                r_id_instr   <= i_if_instruction;
            end
        end
    end

    assign o_id_valid         = r_id_valid;
    assign o_id_pc_next       = r_id_pc_next;
    assign o_id_instruction   = r_id_instr;
    assign o_id_opcode        = r_id_instr[31:26];
    assign o_id_rs            = r_id_instr[25:21];
    assign o_id_rt            = r_id_instr[20:16];
    assign o_id_rd            = r_id_instr[15:11];
    assign o_id_funct         = r_id_instr[5:0];
    assign o_id_imm_sext      = {{16{r_id_instr[15]}}, r_id_instr[15:0]};
    assign o_id_branch_target = r_id_pc_next + {o_id_imm_sext[29:0], 2'b00};

`ifdef IF_ID_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_flush_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (i_mem_branch_taken && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (i_id_stall && !i_mem_branch_taken && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_flush_count = r_flush_cnt;
    assign o_stall_count = r_stall_cnt;
`else
    // Performance counters not built.
`endif

endmodule
